// File: rtl/ask_uart_pkg.sv
`default_nettype none
// ============================================================================
// Module : ask_uart_pkg
// Brief  : Shared ASK UART definitions: FSM states, frame width, level decode.
// Rev    : 1.0  initial release
// ============================================================================
package ask_uart_pkg;

    localparam int UART_DATA_BITS = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } uart_state_t;

    // Upper amplitude levels (2'b10/2'b11) are mark, lower two are space.
    function automatic logic ask_to_bit(input logic [1:0] level);
        return level[1];
    endfunction

endpackage
`default_nettype wire

// File: rtl/ask_uart_rx_core.sv
`default_nettype none
// ============================================================================
// Module : ask_uart_rx_core
// Brief  : 8N1 receiver: synchroniser, baud counter, 3-sample voter and FSM.
// Rev    : 1.0  initial release
// ============================================================================
module ask_uart_rx_core
    import ask_uart_pkg::*;
#(
    parameter int unsigned clkdiv_rx = 100
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [1:0]                ask_rx,
    output logic [UART_DATA_BITS-1:0] rx_data,
    output logic                      rx_push,
    output logic                      frame_err
);

    localparam logic [15:0] c_CENTRE = 16'(clkdiv_rx / 2);
    localparam logic [15:0] c_LAST   = 16'(clkdiv_rx - 1);
    localparam logic [2:0]  c_LAST_BIT = 3'(UART_DATA_BITS - 1);

    logic [1:0]                r_sync1;
    logic [1:0]                r_sync2;
    logic                      r_line_prev;
    logic                      w_line;
    uart_state_t               r_state;
    uart_state_t               w_state_next;
    logic [15:0]               r_cnt;
    logic [2:0]                r_bit_cnt;
    logic [UART_DATA_BITS-1:0] r_shift;
    logic                      r_s0;
    logic                      r_s1;
    logic                      r_push;
    logic                      r_ferr;
    logic                      w_vote;
    logic                      w_decide;
    logic                      w_shift_en;
    logic                      w_push_set;
    logic                      w_ferr_set;

    assign w_line   = ask_to_bit(r_sync2);
    // Third sample is the live line value, so the vote resolves at centre+1.
    assign w_vote   = (r_s0 & r_s1) | (r_s0 & w_line) | (r_s1 & w_line);
    assign w_decide = (r_cnt == c_CENTRE + 16'd1);

    always_comb begin
        w_state_next = r_state;
        w_shift_en   = 1'b0;
        w_push_set   = 1'b0;
        w_ferr_set   = 1'b0;
        case (r_state)
            IDLE: begin
                if (r_line_prev && !w_line) begin
                    w_state_next = START;
                end
            end
            START: begin
                if (w_decide) begin
                    w_state_next = w_vote ? IDLE : DATA;
                end
            end
            DATA: begin
                if (w_decide) begin
                    w_shift_en = 1'b1;
                    if (r_bit_cnt == c_LAST_BIT) begin
                        w_state_next = STOP;
                    end
                end
            end
            STOP: begin
                if (w_decide) begin
                    w_state_next = IDLE;
                    w_push_set   = w_vote;
                    w_ferr_set   = !w_vote;
                end
            end
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync1     <= 2'b11;
            r_sync2     <= 2'b11;
            r_line_prev <= 1'b1;
            r_state     <= IDLE;
            r_cnt       <= 16'd0;
            r_bit_cnt   <= 3'd0;
            r_shift     <= '0;
            r_s0        <= 1'b1;
            r_s1        <= 1'b1;
            r_push      <= 1'b0;
            r_ferr      <= 1'b0;
        end else begin
            r_sync1     <= ask_rx;
            r_sync2     <= r_sync1;
            r_line_prev <= w_line;
            r_state     <= w_state_next;
            r_push      <= w_push_set;
            r_ferr      <= w_ferr_set;

            // Counter is phase-locked to the start edge and wraps every bit period.
            if (r_state == IDLE || r_cnt == c_LAST) begin
                r_cnt <= 16'd0;
            end else begin
                r_cnt <= r_cnt + 16'd1;
            end

            if (r_cnt == c_CENTRE - 16'd1) begin
                r_s0 <= w_line;
            end
            if (r_cnt == c_CENTRE) begin
                r_s1 <= w_line;
            end

            if (r_state == START) begin
                r_bit_cnt <= 3'd0;
            end else if (w_shift_en) begin
                r_bit_cnt <= r_bit_cnt + 3'd1;
            end

            if (w_shift_en) begin
                r_shift <= {w_vote, r_shift[UART_DATA_BITS-1:1]};
            end
        end
    end

    assign rx_data   = r_shift;
    assign rx_push   = r_push;
    assign frame_err = r_ferr;

endmodule
`default_nettype wire

// File: rtl/axis_ask_uart_rx.sv
`default_nettype none
// ============================================================================
// Module : axis_ask_uart_rx
// Brief  : ASK UART receiver with byte FIFO and AXI-Stream master output.
// Rev    : 1.0  initial release
// ============================================================================
module axis_ask_uart_rx
    import ask_uart_pkg::*;
#(
    parameter int unsigned RX_SIZE   = 16,
    parameter int unsigned clkdiv_rx = 100
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [1:0]  ask_rx,
    output logic [7:0]  o_tdata,
    output logic        o_tvalid,
    input  logic        o_tready,
    output logic [15:0] fifo_level,
    output logic        frame_err,
    output logic        overrun
);

    localparam int          c_PTR_W      = $clog2(RX_SIZE);
    localparam logic [15:0] c_FULL_LEVEL = 16'(RX_SIZE);

    logic [UART_DATA_BITS-1:0] w_rx_data;
    logic                      w_rx_push;
    logic                      w_frame_err;
    logic [7:0]                r_mem [RX_SIZE];
    logic [c_PTR_W-1:0]        r_wr_ptr;
    logic [c_PTR_W-1:0]        r_rd_ptr;
    logic [15:0]               r_level;
    logic                      r_overrun;
    logic                      w_full;
    logic                      w_pop;
    logic                      w_wr_en;

    ask_uart_rx_core #(
        .clkdiv_rx (clkdiv_rx)
    ) u_core (
        .clk       (clk),
        .rst       (rst),
        .ask_rx    (ask_rx),
        .rx_data   (w_rx_data),
        .rx_push   (w_rx_push),
        .frame_err (w_frame_err)
    );

    assign w_full  = (r_level == c_FULL_LEVEL);
    assign w_pop   = o_tvalid & o_tready;
    // A simultaneous pop frees the slot, so a full FIFO still accepts the byte.
    assign w_wr_en = w_rx_push & (!w_full | w_pop);

    always_ff @(posedge clk) begin
        if (w_wr_en) begin
            r_mem[r_wr_ptr] <= w_rx_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr  <= '0;
            r_rd_ptr  <= '0;
            r_level   <= 16'd0;
            r_overrun <= 1'b0;
        end else begin
            r_overrun <= w_rx_push & w_full & !w_pop;
            if (w_wr_en) begin
                r_wr_ptr <= r_wr_ptr + c_PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_PTR_W'(1);
            end
            if (w_wr_en && !w_pop) begin
                r_level <= r_level + 16'd1;
            end else if (w_pop && !w_wr_en) begin
                r_level <= r_level - 16'd1;
            end
        end
    end

    assign o_tvalid   = (r_level != 16'd0);
    assign o_tdata    = o_tvalid ? r_mem[r_rd_ptr] : 8'h00;
    assign fifo_level = r_level;
    assign frame_err  = w_frame_err;
    assign overrun    = r_overrun;

endmodule
`default_nettype wire

// File: tb/tb_axis_ask_uart_rx.sv
`default_nettype none
// ============================================================================
// Module : tb_axis_ask_uart_rx
// Brief  : Directed and randomized bench for axis_ask_uart_rx with a byte model.
// Rev    : 1.0  initial release
// ============================================================================
module tb_axis_ask_uart_rx;

    localparam int c_CLKDIV = 16;
    localparam int c_RXS    = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [1:0]  ask_rx = 2'b11;
    logic        o_tready = 1'b0;
    logic [7:0]  o_tdata;
    logic        o_tvalid;
    logic [15:0] fifo_level;
    logic        frame_err;
    logic        overrun;

    axis_ask_uart_rx #(
        .RX_SIZE   (c_RXS),
        .clkdiv_rx (c_CLKDIV)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .ask_rx     (ask_rx),
        .o_tdata    (o_tdata),
        .o_tvalid   (o_tvalid),
        .o_tready   (o_tready),
        .fifo_level (fifo_level),
        .frame_err  (frame_err),
        .overrun    (overrun)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;
    int ferr_cnt = 0;
    int ovr_cnt  = 0;
    int both_cnt = 0;
    int tv_cnt   = 0;
    int exp_ferr = 0;
    int exp_ovr  = 0;
    int mlevel   = 0;
    int max_level = 0;
    bit lvl_fixed = 1'b0;
    logic [7:0] got_q[$];
    logic [7:0] exp_q[$];

    always @(negedge clk) begin
        #1;
        if (o_tvalid && o_tready) got_q.push_back(o_tdata);
        if (frame_err) ferr_cnt++;
        if (overrun) ovr_cnt++;
        if (frame_err && overrun) both_cnt++;
        if (o_tvalid) tv_cnt++;
        if (int'(fifo_level) > max_level) max_level = int'(fifo_level);
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    function automatic logic [1:0] line_level(input logic b);
        if (lvl_fixed) return b ? 2'b10 : 2'b01;
        return {b, 1'($urandom_range(0, 1))};
    endfunction

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            ask_rx = line_level(1'b1);
        end
    endtask

    // Model: which bytes the FIFO accepts and which error pulses occur.
    // mode 0: consumer always ready, 1: consumer stalled, 2: pop coincides with push
    task automatic model_rx(input logic [7:0] d, input logic stop, input int mode);
        if (!stop) begin
            exp_ferr++;
        end else if (mlevel == c_RXS && mode != 2) begin
            exp_ovr++;
        end else begin
            exp_q.push_back(d);
            if (mode == 1) mlevel++;
        end
    endtask

    task automatic send_frame(input logic [7:0] data, input logic stop, input int glitch_bit,
                              input int rst_bit, input bit pop_at_push);
        logic [9:0] frame;
        logic [1:0] lv;
        frame = {stop, data, 1'b0};
        for (int b = 0; b < 10; b++) begin
            lv = line_level(frame[b]);
            for (int c = 0; c < c_CLKDIV; c++) begin
                @(negedge clk);
                if (b == rst_bit && c == 0) begin
                    rst    = 1'b1;
                    ask_rx = 2'b11;
                    repeat (3) @(negedge clk);
                    check("rst_tvalid", 32'(o_tvalid), 32'd0);
                    check("rst_tdata", 32'(o_tdata), 32'd0);
                    check("rst_level", 32'(fifo_level), 32'd0);
                    check("rst_frame_err", 32'(frame_err), 32'd0);
                    check("rst_overrun", 32'(overrun), 32'd0);
                    rst = 1'b0;
                    idle(2 * c_CLKDIV);
                    return;
                end
                ask_rx = (b == glitch_bit && c == 9) ? line_level(!frame[b]) : lv;
                if (pop_at_push) o_tready = (b == 9 && c == 13);
            end
        end
        idle(4);
    endtask

    task automatic drain_and_compare(input string tag);
        int n;
        o_tready = 1'b1;
        repeat (3 * c_RXS + 4) @(negedge clk);
        mlevel = 0;
        check({tag, "_count"}, 32'(got_q.size()), 32'(exp_q.size()));
        n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
        for (int i = 0; i < n; i++) begin
            check({tag, "_byte"}, 32'(got_q[i]), 32'(exp_q[i]));
        end
        got_q.delete();
        exp_q.delete();
        check({tag, "_level"}, 32'(fifo_level), 32'd0);
        check({tag, "_ferr"}, 32'(ferr_cnt), 32'(exp_ferr));
        check({tag, "_ovr"}, 32'(ovr_cnt), 32'(exp_ovr));
    endtask

    initial begin
        logic [7:0] d;
        logic       s;

        repeat (5) @(negedge clk);
        check("reset_tvalid", 32'(o_tvalid), 32'd0);
        check("reset_tdata", 32'(o_tdata), 32'd0);
        check("reset_level", 32'(fifo_level), 32'd0);
        check("reset_ferr", 32'(frame_err), 32'd0);
        check("reset_ovr", 32'(overrun), 32'd0);
        rst = 1'b0;
        idle(20);

        // single byte, consumer ready
        o_tready  = 1'b1;
        tv_cnt    = 0;
        max_level = 0;
        send_frame(8'hA5, 1'b1, -1, -1, 1'b0);
        model_rx(8'hA5, 1'b1, 0);
        idle(4);
        check("t1_tvalid_cycles", 32'(tv_cnt), 32'd1);
        check("t1_max_level", 32'(max_level), 32'd1);
        drain_and_compare("t1");

        // overflow with stalled consumer
        o_tready = 1'b0;
        for (int i = 1; i <= 5; i++) begin
            send_frame(8'(i), 1'b1, -1, -1, 1'b0);
            model_rx(8'(i), 1'b1, 1);
        end
        check("t2_level_full", 32'(fifo_level), 32'(c_RXS));
        check("t2_ovr_once", 32'(ovr_cnt), 32'(exp_ovr));
        drain_and_compare("t2");

        // framing error then good byte
        send_frame(8'h3C, 1'b0, -1, -1, 1'b0);
        model_rx(8'h3C, 1'b0, 0);
        check("t3_level", 32'(fifo_level), 32'd0);
        check("t3_ferr", 32'(ferr_cnt), 32'(exp_ferr));
        send_frame(8'h55, 1'b1, -1, -1, 1'b0);
        model_rx(8'h55, 1'b1, 0);
        drain_and_compare("t3");

        // short start glitch, then data-bit glitch
        repeat (3) begin
            @(negedge clk);
            ask_rx = line_level(1'b0);
        end
        idle(3 * c_CLKDIV);
        check("t4_glitch_nopush", 32'(got_q.size()), 32'd0);
        check("t4_glitch_level", 32'(fifo_level), 32'd0);
        check("t4_glitch_ferr", 32'(ferr_cnt), 32'(exp_ferr));
        send_frame(8'h00, 1'b1, 3, -1, 1'b0);
        model_rx(8'h00, 1'b1, 0);
        drain_and_compare("t4");

        // reset mid-frame flushes FIFO and aborts frame
        o_tready = 1'b0;
        send_frame(8'h99, 1'b1, -1, -1, 1'b0);
        model_rx(8'h99, 1'b1, 1);
        check("t5_level_before", 32'(fifo_level), 32'd1);
        send_frame(8'h81, 1'b1, -1, 5, 1'b0);
        void'(exp_q.pop_back());
        mlevel = 0;
        check("t5_level_after", 32'(fifo_level), 32'd0);
        o_tready = 1'b1;
        send_frame(8'h42, 1'b1, -1, -1, 1'b0);
        model_rx(8'h42, 1'b1, 0);
        drain_and_compare("t5");

        // full FIFO with pop coinciding with push, fixed mid amplitude levels
        lvl_fixed = 1'b1;
        o_tready  = 1'b0;
        for (int i = 0; i < c_RXS; i++) begin
            d = 8'($urandom);
            send_frame(d, 1'b1, -1, -1, 1'b0);
            model_rx(d, 1'b1, 1);
        end
        check("t6_level_full", 32'(fifo_level), 32'(c_RXS));
        d = 8'($urandom);
        send_frame(d, 1'b1, -1, -1, 1'b1);
        model_rx(d, 1'b1, 2);
        check("t6_level_kept", 32'(fifo_level), 32'(c_RXS));
        check("t6_no_ovr", 32'(ovr_cnt), 32'(exp_ovr));
        drain_and_compare("t6");

        // randomized stream with occasional bad stop bits
        lvl_fixed = 1'b0;
        o_tready  = 1'b1;
        for (int i = 0; i < 8; i++) begin
            d = 8'($urandom);
            s = ($urandom_range(0, 3) != 0);
            send_frame(d, s, -1, -1, 1'b0);
            model_rx(d, s, 0);
        end
        drain_and_compare("rand");

        check("never_both_pulses", 32'(both_cnt), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
